// File: rtl/wb_resp_pkg.sv
// rtl/wb_resp_pkg.sv - shared types and constants for the Wishbone memory responder
package wb_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [31:0] ID_VALUE = 32'h0600_5EED;
  localparam logic [31:0] BAD_READ = 32'hDEAD_BEEF;

  localparam logic [31:0] CSR_ID_OFF      = 32'h0000_0000;
  localparam logic [31:0] CSR_COUNT_OFF   = 32'h0000_0004;
  localparam logic [31:0] CSR_SCRATCH_OFF = 32'h0000_0008;

endpackage

// File: rtl/wb_bytemem.sv
// rtl/wb_bytemem.sv - word memory with byte-lane write enables and a registered read port
module wb_bytemem #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read-first behaviour keeps this a plain single-port block RAM template.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_mem_responder.sv
// rtl/wb_mem_responder.sv - Wishbone classic responder: byte-writable memory plus ID/counter/scratch CSRs
module wb_mem_responder
  import wb_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] CSR_OFFSET  = 32'h0000_1000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WS_INIT   = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] adr_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;

  logic [31:0] access_count_q;
  logic [31:0] scratch_q;
  logic [31:0] csr_rdata_q;
  logic        mem_sel_q;

  logic        req, commit;
  logic [29:0] c_adr;
  logic        c_we;
  logic [3:0]  c_sel;
  logic [31:0] c_dat;
  logic [31:0] off;
  logic        is_mem, is_id, is_count, is_scratch;
  logic [31:0] mem_rdata;
  logic        unused_adr_lsbs;

  assign req             = wbs_cyc_i & wbs_stb_i;
  assign unused_adr_lsbs = ^wbs_adr_i[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = ACK;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_INIT;
          end
        end
      end
      WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the commit edge is also the sampling edge, so the live bus is used.
  always_comb begin
    c_adr = adr_q;
    c_we  = we_q;
    c_sel = sel_q;
    c_dat = dat_q;
    if (state_q == IDLE) begin
      c_adr = wbs_adr_i[31:2];
      c_we  = wbs_we_i;
      c_sel = wbs_sel_i;
      c_dat = wbs_dat_i;
    end
  end

  assign off        = {c_adr, 2'b00} - BASE_ADDR;
  assign is_mem     = off < MEM_BYTES;
  assign is_id      = off == CSR_OFFSET + CSR_ID_OFF;
  assign is_count   = off == CSR_OFFSET + CSR_COUNT_OFF;
  assign is_scratch = off == CSR_OFFSET + CSR_SCRATCH_OFF;

  wb_bytemem #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem (
    .clk  (clk),
    .en   (commit & is_mem),
    .we   ((commit & is_mem & c_we) ? c_sel : 4'b0000),
    .addr (off[AW+1:2]),
    .wdata(c_dat),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      adr_q          <= '0;
      we_q           <= 1'b0;
      sel_q          <= 4'b0000;
      dat_q          <= '0;
      access_count_q <= '0;
      scratch_q      <= '0;
      csr_rdata_q    <= '0;
      mem_sel_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        adr_q <= wbs_adr_i[31:2];
        we_q  <= wbs_we_i;
        sel_q <= wbs_sel_i;
        dat_q <= wbs_dat_i;
      end
      if (commit) begin
        access_count_q <= access_count_q + 32'd1;
        mem_sel_q      <= is_mem;
        if (is_id)           csr_rdata_q <= ID_VALUE;
        else if (is_count)   csr_rdata_q <= access_count_q;
        else if (is_scratch) csr_rdata_q <= scratch_q;
        else                 csr_rdata_q <= BAD_READ;
        if (is_scratch && c_we) begin
          for (int i = 0; i < 4; i++) begin
            if (c_sel[i]) scratch_q[8*i +: 8] <= c_dat[8*i +: 8];
          end
        end
      end
    end
  end

  assign wbs_ack_o = (state_q == ACK);
  assign wbs_dat_o = wbs_ack_o ? (mem_sel_q ? mem_rdata : csr_rdata_q) : 32'h0;

endmodule

// File: tb/tb_wb_mem_responder.sv
// tb/tb_wb_mem_responder.sv - randomized self-checking bench over three wait-state configurations
module tb_wb_mem_responder;

  localparam logic [31:0] BASE = 32'h3300_0000;

  logic        clk  = 1'b0;
  logic        nrst = 1'b0;
  logic [2:0]  cyc_v = '0;
  logic [2:0]  stb_v = '0;
  logic        we    = 1'b0;
  logic [3:0]  sel   = '0;
  logic [31:0] adr   = '0;
  logic [31:0] wdat  = '0;
  logic [2:0]  ack_v;
  logic [31:0] rdat [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_mem_responder #(
      .BASE_ADDR  (BASE),
      .DEPTH_WORDS(256),
      .CSR_OFFSET (32'h0000_1000),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk      (clk),
      .nrst     (nrst),
      .wbs_cyc_i(cyc_v[g]),
      .wbs_stb_i(stb_v[g]),
      .wbs_we_i (we),
      .wbs_sel_i(sel),
      .wbs_adr_i(adr),
      .wbs_dat_i(wdat),
      .wbs_ack_o(ack_v[g]),
      .wbs_dat_o(rdat[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mmem [3][256];
  logic [31:0] mcnt [3];
  logic [31:0] mscr [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_access(input int k, input bit w, input logic [31:0] a,
                                               input logic [3:0] s, input logic [31:0] d);
    logic [31:0] o, r;
    o = {a[31:2], 2'b00} - BASE;
    if (o < 32'd1024) begin
      r = mmem[k][o[9:2]];
      if (w) mmem[k][o[9:2]] = merge(r, d, s);
    end else if (o == 32'h1000) r = 32'h0600_5EED;
    else if (o == 32'h1004) r = mcnt[k];
    else if (o == 32'h1008) begin
      r = mscr[k];
      if (w) mscr[k] = merge(r, d, s);
    end else r = 32'hDEAD_BEEF;
    mcnt[k] = mcnt[k] + 32'd1;
    return r;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 5);
  endfunction

  task automatic xfer(input int k, input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input string tag);
    int n;
    logic [31:0] got, exp;
    @(negedge clk);
    cyc_v = 3'(1 << k); stb_v = 3'(1 << k); we = w; adr = a; sel = s; wdat = d;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack_v[k] && n < 40);
    got = rdat[k];
    exp = model_access(k, w, a, s, d);
    check({tag, " latency"}, n, lat_of(k));
    if (!w) check({tag, " data"}, got, exp);
    @(negedge clk);
    cyc_v = '0; stb_v = '0; we = 1'b0;
    @(posedge clk); #1;
    check({tag, " post"}, ack_v[k] ? 32'hFFFF_FFFF : rdat[k], 32'h0);
  endtask

  initial begin
    int pulses;
    bit pat_ok;
    int k, r, w;
    logic [31:0] a;
    logic [31:0] bad [4];
    bad = '{BASE + 32'h400, BASE - 32'h4, BASE + 32'h2000, BASE + 32'h100C};
    for (int i = 0; i < 3; i++) begin mcnt[i] = 0; mscr[i] = 0; end

    repeat (3) @(posedge clk);
    #1;
    check("reset ack", {29'b0, ack_v}, 32'h0);
    for (int i = 0; i < 3; i++) check("reset dat", rdat[i], 32'h0);
    @(negedge clk); nrst = 1'b1;

    xfer(1, 0, BASE + 32'h1000, 4'hF, 0, "id read");
    xfer(1, 0, BASE + 32'h1004, 4'hF, 0, "count after one");

    xfer(1, 1, BASE + 32'h10, 4'hF, 32'hA1B2_C3D4, "full write");
    xfer(1, 1, BASE + 32'h10, 4'b0001, 32'h0000_00FF, "lane write");
    xfer(1, 0, BASE + 32'h10, 4'hF, 0, "lane readback");

    for (int kk = 0; kk < 3; kk++) begin
      for (int ww = 0; ww < 17; ww++) begin
        w = (ww == 16) ? 255 : ww;
        xfer(kk, 1, BASE + 32'(4 * w), 4'hF, $urandom, "init");
      end
    end
    xfer(2, 1, BASE + 32'h3FC, 4'b0000, 32'h5555_5555, "sel0 write");
    xfer(2, 0, BASE + 32'h3FC, 4'hF, 0, "sel0 readback");

    for (int it = 0; it < 150; it++) begin
      k = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        w = $urandom_range(0, 16);
        if (w == 16) w = 255;
        a = BASE + 32'(4 * w);
      end else if (r == 6) a = BASE + 32'h1000;
      else if (r == 7) a = BASE + 32'h1004;
      else if (r == 8) a = BASE + 32'h1008;
      else a = bad[$urandom_range(0, 3)];
      a[1:0] = 2'($urandom_range(0, 3));
      xfer(k, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, "random");
    end

    @(negedge clk);
    cyc_v = 3'b001; stb_v = 3'b001; we = 1'b0; adr = BASE + 32'hC;
    pulses = 0; pat_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack_v[0]) begin
        pulses++;
        if (rdat[0] !== mmem[0][3]) pat_ok = 1'b0;
      end
      if (ack_v[0] !== (i % 2 == 0)) pat_ok = 1'b0;
      if (i == 6) begin
        @(negedge clk); cyc_v = '0; stb_v = '0;
      end
    end
    for (int j = 0; j < 4; j++) void'(model_access(0, 0, BASE + 32'hC, 4'hF, 0));
    check("b2b pulses", pulses, 4);
    check("b2b pattern", {31'b0, pat_ok}, 32'h1);
    xfer(0, 0, BASE + 32'h1004, 4'hF, 0, "b2b count");

    xfer(1, 1, BASE + 32'h1000, 4'hF, 32'h1111_2222, "id write");
    xfer(1, 0, BASE + 32'h1000, 4'hF, 0, "id after write");
    xfer(1, 0, BASE + 32'h2000, 4'hF, 0, "unmapped read");

    @(negedge clk);
    cyc_v = 3'b100; stb_v = 3'b100; we = 1'b1; adr = BASE; sel = 4'hF; wdat = 32'h1234;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    cyc_v = '0; stb_v = '0; we = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack_v[2]) pulses++;
    end
    check("abort no ack", pulses, 0);
    xfer(2, 0, BASE, 4'hF, 0, "abort readback");
    xfer(2, 0, BASE + 32'h1004, 4'hF, 0, "abort count");

    xfer(2, 1, BASE + 32'h1008, 4'hF, 32'h0BAD_F00D, "scratch set");
    @(negedge clk);
    cyc_v = 3'b100; stb_v = 3'b100; we = 1'b1; adr = BASE + 32'h1008; sel = 4'hF; wdat = 32'hCAFE_F00D;
    @(posedge clk);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    check("reset mid ack", {29'b0, ack_v}, 32'h0);
    check("reset mid dat", rdat[2], 32'h0);
    cyc_v = '0; stb_v = '0; we = 1'b0;
    @(negedge clk); nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin mcnt[i] = 0; mscr[i] = 0; end
    xfer(2, 0, BASE + 32'h1008, 4'hF, 0, "scratch after reset");
    xfer(2, 0, BASE + 32'h1004, 4'hF, 0, "count after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
